// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, next-PC selection, fetch address check and IF/ID pipeline register.
// Optional macro IF_PERF_CNT_EN adds the fetch_count / nullify_count performance outputs.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LAST    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        id_eret,
  input  logic [31:0] cp0_epc,
  input  logic        id_pc_jump,
  input  logic [31:0] id_npc_target,
  input  logic        id_has_delay_slot,
  input  logic        id_nullify_delay_slot,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] PC4,
  output logic        exception,
  output logic [31:0] EPC,
  output logic [4:0]  ExcCode,
  output logic        BD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] nullify_count
`endif
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        fetch_fault;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Misaligned or outside the instruction memory window raises AdEL.
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);

  always_comb begin
    next_pc = pc_plus4;
    if (exc_req)
      next_pc = HANDLER_PC;
    else if (stall)
      next_pc = pc;
    else if (id_eret)
      next_pc = cp0_epc;
    else if (id_pc_jump)
      next_pc = id_npc_target;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  // IF/ID register; exc_req flushes the slot so the handler starts from a clean pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      Inst      <= 32'h0;
      PC4       <= RESET_PC + 32'd4;
      exception <= 1'b0;
      EPC       <= 32'h0;
      ExcCode   <= 5'd0;
      BD        <= 1'b0;
    end else if (exc_req) begin
      Inst      <= 32'h0;
      PC4       <= HANDLER_PC + 32'd4;
      exception <= 1'b0;
      EPC       <= 32'h0;
      ExcCode   <= 5'd0;
      BD        <= 1'b0;
    end else if (!stall) begin
      PC4 <= pc_plus4;
      if (id_nullify_delay_slot) begin
        Inst      <= 32'h0;
        exception <= 1'b0;
        EPC       <= pc;
        ExcCode   <= 5'd0;
        BD        <= 1'b0;
      end else begin
        Inst      <= fetch_fault ? 32'h0 : imem_rdata;
        exception <= fetch_fault;
        EPC       <= id_has_delay_slot ? (pc - 32'd4) : pc;
        ExcCode   <= fetch_fault ? EXC_ADEL : 5'd0;
        BD        <= id_has_delay_slot;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count   <= 32'h0;
      nullify_count <= 32'h0;
    end else if (!exc_req && !stall) begin
      fetch_count <= fetch_count + 32'd1;
      if (id_nullify_delay_slot)
        nullify_count <= nullify_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LAST    = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        id_eret;
  logic [31:0] cp0_epc;
  logic        id_pc_jump;
  logic [31:0] id_npc_target;
  logic        id_has_delay_slot;
  logic        id_nullify_delay_slot;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Inst;
  logic [31:0] PC4;
  logic        exception;
  logic [31:0] EPC;
  logic [4:0]  ExcCode;
  logic        BD;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: architectural PC plus the IF/ID contents decode should see.
  logic [31:0] m_pc, m_inst, m_pc4, m_epc;
  logic        m_exc, m_bd;
  logic [4:0]  m_code;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .exc_req              (exc_req),
    .id_eret              (id_eret),
    .cp0_epc              (cp0_epc),
    .id_pc_jump           (id_pc_jump),
    .id_npc_target        (id_npc_target),
    .id_has_delay_slot    (id_has_delay_slot),
    .id_nullify_delay_slot(id_nullify_delay_slot),
    .imem_addr            (imem_addr),
    .imem_rdata           (imem_rdata),
    .Inst                 (Inst),
    .PC4                  (PC4),
    .exception            (exception),
    .EPC                  (EPC),
    .ExcCode              (ExcCode),
    .BD                   (BD)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  function automatic bit is_fault(input logic [31:0] a);
    longint unsigned ua = a;
    return (ua % 4 != 0) || (ua < IM_BASE) || (ua > IM_LAST);
  endfunction

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic modelStep();
    logic [31:0] cur = m_pc;
    if (reset) begin
      m_pc = RESET_PC; m_inst = 0; m_pc4 = RESET_PC + 4;
      m_exc = 0; m_epc = 0; m_code = 0; m_bd = 0;
    end else if (exc_req) begin
      m_pc = HANDLER_PC; m_inst = 0; m_pc4 = HANDLER_PC + 4;
      m_exc = 0; m_epc = 0; m_code = 0; m_bd = 0;
    end else if (!stall) begin
      m_pc4 = cur + 4;
      if (id_nullify_delay_slot) begin
        m_inst = 0; m_exc = 0; m_code = 0; m_bd = 0; m_epc = cur;
      end else begin
        m_exc  = is_fault(cur);
        m_inst = m_exc ? 32'h0 : mem_word(cur);
        m_code = m_exc ? 5'd4 : 5'd0;
        m_bd   = id_has_delay_slot;
        m_epc  = id_has_delay_slot ? cur - 4 : cur;
      end
      if (id_eret)         m_pc = cp0_epc;
      else if (id_pc_jump) m_pc = id_npc_target;
      else                 m_pc = cur + 4;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("Inst", Inst, m_inst);
    checkOutput("PC4", PC4, m_pc4);
    checkOutput("exception", {31'b0, exception}, {31'b0, m_exc});
    checkOutput("EPC", EPC, m_epc);
    checkOutput("ExcCode", {27'b0, ExcCode}, {27'b0, m_code});
    checkOutput("BD", {31'b0, BD}, {31'b0, m_bd});
  endtask

  task automatic applyStimulus(input bit st, input bit ex, input bit er, input logic [31:0] epc,
                               input bit jp, input logic [31:0] tgt, input bit ds, input bit nl);
    stall = st; exc_req = ex; id_eret = er; cp0_epc = epc;
    id_pc_jump = jp; id_npc_target = tgt; id_has_delay_slot = ds; id_nullify_delay_slot = nl;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  function automatic logic [31:0] randTarget();
    case ($urandom_range(0, 3))
      0:       return IM_BASE + 32'(4 * $urandom_range(0, 32'hFFF));
      1:       return IM_BASE + 32'($urandom_range(0, 32'h3FFF)) | 32'h1;
      2:       return IM_LAST - 32'(4 * $urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_pc = 0; m_inst = 0; m_pc4 = 0; m_exc = 0; m_epc = 0; m_code = 0; m_bd = 0;

    reset = 1;
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOutput("reset_addr", imem_addr, 32'h3000);
    checkOutput("reset_pc4", PC4, 32'h3004);
    reset = 0;

    idle();
    checkOutput("seq_addr1", imem_addr, 32'h3004);
    idle();
    checkOutput("seq_addr2", imem_addr, 32'h3008);
    checkOutput("seq_pc4", PC4, 32'h3008);

    // Taken jump whose delay slot sits at 0x3008.
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h3100, 1, 0);
    checkOutput("slot_bd", {31'b0, BD}, 32'h1);
    checkOutput("slot_epc", EPC, 32'h3004);
    checkOutput("jump_addr", imem_addr, 32'h3100);

    applyStimulus(0, 0, 0, 32'h0, 1, 32'h3100, 1, 1);
    checkOutput("null_inst", Inst, 32'h0);
    checkOutput("null_bd", {31'b0, BD}, 32'h0);

    // Misaligned target faults on the following capture.
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h3102, 0, 0);
    idle();
    checkOutput("adel_exc", {31'b0, exception}, 32'h1);
    checkOutput("adel_code", {27'b0, ExcCode}, 32'h4);
    checkOutput("adel_epc", EPC, 32'h3102);

    // Last legal word, then the first word past the window.
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h6FF8, 0, 0);
    idle();
    idle();
    checkOutput("last_ok", {31'b0, exception}, 32'h0);
    idle();
    checkOutput("past_last", {31'b0, exception}, 32'h1);

    applyStimulus(1, 0, 0, 32'h0, 1, 32'h3200, 0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h3200, 0, 0);
    checkOutput("stall_hold", imem_addr, 32'h7004);
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h3200, 0, 0);
    checkOutput("post_stall_jump", imem_addr, 32'h3200);

    applyStimulus(1, 1, 0, 32'h0, 1, 32'h3300, 0, 0);
    checkOutput("exc_addr", imem_addr, 32'h4180);
    checkOutput("exc_pc4", PC4, 32'h4184);
    applyStimulus(0, 0, 1, 32'h3040, 0, 32'h0, 0, 0);
    checkOutput("eret_addr", imem_addr, 32'h3040);

    applyStimulus(0, 0, 1, 32'h3080, 0, 32'h0, 0, 1);
    checkOutput("eret_null_addr", imem_addr, 32'h3080);

    // PC wraps through zero and keeps faulting.
    applyStimulus(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0);
    idle();
    checkOutput("wrap_addr", imem_addr, 32'h0);
    idle();

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0, IM_BASE + 32'(4 * $urandom_range(0, 32'hFFF)),
                    $urandom_range(0, 5) == 0, randTarget(),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
